// File: rtl/led_scan_driver.sv
// led_scan_driver: consumer end of the painter pixel interface.
// Requests pixels from a painter24-style source, thresholds each returned
// colour against the current PWM subframe and shifts top/bottom half bits into
// a 64x64, 1/32-scan HUB75 panel. One row is shifted while the previously
// latched row is displayed.
module led_scan_driver #(
  parameter int DELAY      = 2,
  parameter int FRAME_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [FRAME_BITS-1:0] frame,
  output logic [7:0]            subframe,
  output logic [5:0]            x,
  output logic [5:0]            y,
  input  logic [23:0]           rgb24,
  output logic [2:0]            led_rgb0,
  output logic [2:0]            led_rgb1,
  output logic                  led_clk,
  output logic                  led_lat,
  output logic                  led_blank,
  output logic [4:0]            led_addr,
  output logic                  frame_start
);

  typedef enum logic [2:0] {
    ST_SHIFT   = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_UNBLANK = 3'd4
  } state_t;

  // Drain counter counts 0..DELAY+1 so the last pixel pair is fully shifted out.
  localparam int                    CNT_W      = $clog2(DELAY + 3);
  localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(DELAY + 1);
  localparam logic [6:0]            REQ_LAST   = 7'd127;
  localparam logic [4:0]            ROW_LAST   = 5'd31;
  localparam logic [7:0]            SUB_LAST   = 8'd254;
  localparam logic [FRAME_BITS-1:0] FRAME_ONE  = FRAME_BITS'(1);

  // One bit per channel, {b,g,r}: lit when the channel exceeds the subframe.
  function automatic logic [2:0] thresh(input logic [23:0] px, input logic [7:0] sf);
    thresh = {(px[23:16] > sf), (px[15:8] > sf), (px[7:0] > sf)};
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  logic [6:0]              req_r;
  logic [CNT_W-1:0]        drain_cnt_r;
  logic [4:0]              row_r;
  logic [7:0]              subframe_r;
  logic [FRAME_BITS-1:0]   frame_r;
  logic                    frame_start_r;
  logic [DELAY-1:0]        vpipe_r;
  logic [DELAY-1:0]        tpipe_r;
  logic [2:0]              top_r;
  logic [2:0]              rgb0_r;
  logic [2:0]              rgb1_r;
  logic                    clk_pend_r;
  logic                    led_clk_r;
  logic                    led_lat_r;
  logic                    led_blank_r;
  logic [4:0]              led_addr_r;
  logic                    blank_next_s;
  logic                    lat_next_s;
  logic [4:0]              addr_next_s;
  logic                    issue_s;
  logic                    resp_valid_s;
  logic                    resp_tag_s;
  logic [2:0]              pix_bits_s;

  assign issue_s      = (state_r == ST_SHIFT);
  assign resp_valid_s = vpipe_r[DELAY-1];
  assign resp_tag_s   = tpipe_r[DELAY-1];
  assign pix_bits_s   = thresh(rgb24, subframe_r);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_SHIFT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: shift 128 requests, drain the pipeline, then blank/latch/unblank.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_SHIFT: begin
        if (req_r == REQ_LAST) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          next_state_s = ST_BLANK;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_BLANK:   next_state_s = ST_LATCH;
      ST_LATCH:   next_state_s = ST_UNBLANK;
      ST_UNBLANK: next_state_s = ST_SHIFT;
      default:    next_state_s = ST_SHIFT;
    endcase
  end

  // Output decode: panel control values for the state being entered.
  always_comb begin
    blank_next_s = led_blank_r;
    lat_next_s   = 1'b0;
    addr_next_s  = led_addr_r;
    case (next_state_s)
      ST_BLANK: begin
        blank_next_s = 1'b1;
      end
      ST_LATCH: begin
        blank_next_s = 1'b1;
        lat_next_s   = 1'b1;
        addr_next_s  = row_r;
      end
      ST_UNBLANK: begin
        blank_next_s = 1'b0;
      end
      default: begin
        blank_next_s = led_blank_r;
      end
    endcase
  end

  // Request counter (walks 0..127 during SHIFT) and drain cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_r       <= 7'd0;
      drain_cnt_r <= '0;
    end else begin
      if (state_r == ST_SHIFT) begin
        req_r <= req_r + 7'd1;
      end else begin
        req_r <= 7'd0;
      end
      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + CNT_W'(1);
      end else begin
        drain_cnt_r <= '0;
      end
    end
  end

  // Valid/tag pipeline that travels alongside each painter request.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe_r <= '0;
      tpipe_r <= '0;
    end else begin
      vpipe_r[0] <= issue_s;
      tpipe_r[0] <= req_r[0];
      for (int k = 1; k < DELAY; k++) begin
        vpipe_r[k] <= vpipe_r[k-1];
        tpipe_r[k] <= tpipe_r[k-1];
      end
    end
  end

  // Response capture: hold the top pixel, then present the pair and pulse led_clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_r      <= 3'd0;
      rgb0_r     <= 3'd0;
      rgb1_r     <= 3'd0;
      clk_pend_r <= 1'b0;
      led_clk_r  <= 1'b0;
    end else begin
      clk_pend_r <= resp_valid_s & resp_tag_s;
      led_clk_r  <= clk_pend_r;
      if (resp_valid_s && !resp_tag_s) begin
        top_r <= pix_bits_s;
      end
      if (resp_valid_s && resp_tag_s) begin
        rgb0_r <= top_r;
        rgb1_r <= pix_bits_s;
      end
    end
  end

  // Panel blank/latch/address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_blank_r <= 1'b1;
      led_lat_r   <= 1'b0;
      led_addr_r  <= 5'd0;
    end else begin
      led_blank_r <= blank_next_s;
      led_lat_r   <= lat_next_s;
      led_addr_r  <= addr_next_s;
    end
  end

  // Row, subframe and frame advance when leaving UNBLANK.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r         <= 5'd0;
      subframe_r    <= 8'd0;
      frame_r       <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      if (state_r == ST_UNBLANK) begin
        row_r <= row_r + 5'd1;
        if (row_r == ROW_LAST) begin
          if (subframe_r == SUB_LAST) begin
            subframe_r    <= 8'd0;
            frame_r       <= frame_r + FRAME_ONE;
            frame_start_r <= 1'b1;
          end else begin
            subframe_r <= subframe_r + 8'd1;
          end
        end
      end
    end
  end

  assign frame       = frame_r;
  assign subframe    = subframe_r;
  assign x           = req_r[6:1];
  assign y           = {req_r[0], row_r};
  assign led_rgb0    = rgb0_r;
  assign led_rgb1    = rgb1_r;
  assign led_clk     = led_clk_r;
  assign led_lat     = led_lat_r;
  assign led_blank   = led_blank_r;
  assign led_addr    = led_addr_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: two instances (DELAY=2 and DELAY=3) driven by
// painter models, checked each cycle against a row-phase model of the panel.
module tb_led_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2 = 1'b1, rst3 = 1'b1;
  logic rq2 = 1'b0, rq3 = 1'b0;
  logic [5:0] fr2, fr3, x2, x3, y2, y3;
  logic [7:0] sf2, sf3;
  logic [23:0] rgb2, rgb3;
  logic [2:0] r0_2, r1_2, r0_3, r1_3;
  logic lc2, lc3, lt2, lt3, bl2, bl3, fs2, fs3;
  logic [4:0] ad2, ad3;

  int checks = 0, errors = 0, cyc = 0;

  // Model state per instance (0: DELAY=2, 1: DELAY=3)
  int p_m[2], row_m[2], sub_m[2], frame_m[2], seq_m[2], pulses_m[2], addr_m[2], last_lat[2];
  bit active[2], shown[2], fs_m[2], lat_seen[2], forced[2], reset_done[2];
  int mode[2] = '{0, 0};
  logic [23:0] cval[2] = '{24'h0000FF, 24'h0000FF};
  int fc2, rc2, fc3, rc3;

  led_scan_driver #(.DELAY(2), .FRAME_BITS(6)) u2 (
    .clk(clk), .reset(rst2), .frame(fr2), .subframe(sf2), .x(x2), .y(y2), .rgb24(rgb2),
    .led_rgb0(r0_2), .led_rgb1(r1_2), .led_clk(lc2), .led_lat(lt2), .led_blank(bl2),
    .led_addr(ad2), .frame_start(fs2));

  led_scan_driver #(.DELAY(3), .FRAME_BITS(6)) u3 (
    .clk(clk), .reset(rst3), .frame(fr3), .subframe(sf3), .x(x3), .y(y3), .rgb24(rgb3),
    .led_rgb0(r0_3), .led_rgb1(r1_3), .led_clk(lc3), .led_lat(lt3), .led_blank(bl3),
    .led_addr(ad3), .frame_start(fs3));

  function automatic logic [23:0] pix(input int md, input logic [23:0] cv, input int px,
                                      input int py, input int pf);
    case (md)
      0: return cv;
      1: return {(px == 63) ? 8'hFF : 8'h00, 8'h00, (py < 32) ? 8'hFF : 8'h00};
      default: return cv ^ 24'(px * 66051 + py * 197893 + pf * 723217);
    endcase
  endfunction

  function automatic logic [2:0] thr(input logic [23:0] px, input logic [7:0] sf);
    return {(px[23:16] > sf), (px[15:8] > sf), (px[7:0] > sf)};
  endfunction

  // Painter models: the response appears DELAY cycles after the request
  logic [23:0] pipe2[2], pipe3[3];
  always @(posedge clk) begin
    pipe2[0] <= pix(mode[0], cval[0], int'(x2), int'(y2), int'(fr2));
    pipe2[1] <= pipe2[0];
    pipe3[0] <= pix(mode[1], cval[1], int'(x3), int'(y3), int'(fr3));
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rgb2 = pipe2[1];
  assign rgb3 = pipe3[2];

  // Reset as seen by the DUT at the last rising edge
  always @(posedge clk) begin
    rq2 <= rst2;
    rq3 <= rst3;
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d row-seq %0d phase %0d: got %0h expected %0h",
               name, i, seq_m[i], p_m[i], act, exp);
    end
  endtask

  task automatic check_dut(input int i, input int D, input logic [5:0] fr, input logic [7:0] sf,
                           input logic [5:0] xx, input logic [5:0] yy,
                           input logic [2:0] r0, input logic [2:0] r1,
                           input logic lc, input logic lt, input logic bl, input logic fs,
                           input logic [4:0] ad, input logic rq,
                           output int fcmd, output int rcmd);
    int p, k, P;
    logic exp_clk, exp_blank;
    logic [2:0] e0, e1;
    fcmd = 0;
    rcmd = 0;
    P = 133 + D;
    if (rq) begin
      active[i] = 1'b1; row_m[i] = 0; sub_m[i] = 0; frame_m[i] = 0; shown[i] = 1'b0;
      fs_m[i] = 1'b0; addr_m[i] = 0; pulses_m[i] = 0; lat_seen[i] = 1'b0; p_m[i] = 0;
      chk("rst_clk", i, 32'(lc), 32'd0);
      chk("rst_lat", i, 32'(lt), 32'd0);
      chk("rst_blank", i, 32'(bl), 32'd1);
      chk("rst_addr", i, 32'(ad), 32'd0);
      chk("rst_fs", i, 32'(fs), 32'd0);
      chk("rst_rgb0", i, 32'(r0), 32'd0);
      chk("rst_rgb1", i, 32'(r1), 32'd0);
      chk("rst_x", i, 32'(xx), 32'd0);
      chk("rst_y", i, 32'(yy), 32'd0);
      chk("rst_frame", i, 32'(fr), 32'd0);
      chk("rst_sub", i, 32'(sf), 32'd0);
      p_m[i] = 1;
      rcmd = 2;
    end else if (active[i]) begin
      p = p_m[i];
      if (p < 128) begin
        chk("x", i, 32'(xx), 32'(p / 2));
        chk("y", i, 32'(yy), 32'((p % 2) * 32 + row_m[i]));
      end
      chk("frame", i, 32'(fr), 32'(frame_m[i]));
      chk("subframe", i, 32'(sf), 32'(sub_m[i]));
      chk("frame_start", i, 32'(fs), 32'(p == 0 && fs_m[i]));
      if (p == 0 && seq_m[i] == 32) begin
        chk("wrap_fs_lit", i, 32'(fs), 32'd1);
        chk("wrap_frame_lit", i, 32'(fr), 32'd0);
        chk("wrap_sub_lit", i, 32'(sf), 32'd0);
      end
      exp_clk = (p >= D + 3) && (p <= D + 129) && (((p - D - 3) % 2) == 0);
      chk("led_clk", i, 32'(lc), 32'(exp_clk));
      if (exp_clk) begin
        k = (p - D - 3) / 2;
        e0 = thr(pix(mode[i], cval[i], k, row_m[i], frame_m[i]), 8'(sub_m[i]));
        e1 = thr(pix(mode[i], cval[i], k, row_m[i] + 32, frame_m[i]), 8'(sub_m[i]));
        chk("rgb0", i, 32'(r0), 32'(e0));
        chk("rgb1", i, 32'(r1), 32'(e1));
        pulses_m[i]++;
        if (seq_m[i] == 0 && k == 0) begin
          chk("t1_rgb0_lit", i, 32'(r0), 32'h1);
          chk("t1_rgb1_lit", i, 32'(r1), 32'h1);
        end
        if (seq_m[i] == 1 && k == 0) begin
          chk("t3_first_rgb0_lit", i, 32'(r0), 32'h1);
          chk("t3_first_rgb1_lit", i, 32'(r1), 32'h0);
        end
        if (seq_m[i] == 1 && k == 63) begin
          chk("t3_last_rgb0_lit", i, 32'(r0), 32'h5);
          chk("t3_last_rgb1_lit", i, 32'(r1), 32'h4);
        end
        if (seq_m[i] == 4 && k == 0) chk("t2_sub127_lit", i, 32'(r0), 32'h1);
        if (seq_m[i] == 5 && k == 0) chk("t2_sub128_lit", i, 32'(r0), 32'h0);
      end
      chk("led_lat", i, 32'(lt), 32'(p == D + 131));
      if (p == D + 131) begin
        addr_m[i] = row_m[i];
        chk("pulse_count", i, 32'(pulses_m[i]), 32'd64);
        pulses_m[i] = 0;
        if (lat_seen[i]) chk("row_period", i, 32'(cyc - last_lat[i]), (i == 0) ? 32'd135 : 32'd136);
        last_lat[i] = cyc;
        lat_seen[i] = 1'b1;
      end
      chk("led_addr", i, 32'(ad), 32'(addr_m[i]));
      if (p == D + 130 || p == D + 131) begin
        exp_blank = 1'b1;
      end else begin
        if (p == D + 132) shown[i] = 1'b1;
        exp_blank = !shown[i];
      end
      chk("led_blank", i, 32'(bl), 32'(exp_blank));
      // Jump subframe/frame during LATCH to reach the boundary cases quickly
      if (p == D + 131) begin
        if (seq_m[i] == 3) begin fcmd = 1; sub_m[i] = 127; forced[i] = 1'b1; end
        if (seq_m[i] == 4) begin fcmd = 2; sub_m[i] = 128; forced[i] = 1'b1; end
        if (seq_m[i] == 6) begin fcmd = 3; sub_m[i] = 254; frame_m[i] = 63; forced[i] = 1'b1; end
      end
      if (p == D + 132 && forced[i]) begin
        fcmd = 4;
        forced[i] = 1'b0;
      end
      if (seq_m[i] == 33 && p == 50 && !reset_done[i]) begin
        rcmd = 1;
        reset_done[i] = 1'b1;
      end
      if (p == P - 1) begin
        p_m[i] = 0;
        seq_m[i]++;
        fs_m[i] = 1'b0;
        if (row_m[i] == 31) begin
          row_m[i] = 0;
          if (sub_m[i] == 254) begin
            sub_m[i] = 0;
            frame_m[i] = (frame_m[i] + 1) % 64;
            fs_m[i] = 1'b1;
          end else begin
            sub_m[i]++;
          end
        end else begin
          row_m[i]++;
        end
        if (seq_m[i] == 1) begin
          mode[i] = 1;
        end else if (seq_m[i] == 4 || seq_m[i] == 5) begin
          mode[i] = 0;
          cval[i] = 24'h000080;
        end else begin
          mode[i] = int'($urandom_range(2, 0));
          cval[i] = 24'($urandom);
        end
      end else begin
        p_m[i] = p + 1;
      end
    end
  endtask

  // Single compare process: sample both DUTs away from the rising edge
  always @(negedge clk) begin
    cyc++;
    check_dut(0, 2, fr2, sf2, x2, y2, r0_2, r1_2, lc2, lt2, bl2, fs2, ad2, rq2, fc2, rc2);
    check_dut(1, 3, fr3, sf3, x3, y3, r0_3, r1_3, lc3, lt3, bl3, fs3, ad3, rq3, fc3, rc3);
    case (fc2)
      1: force u2.subframe_r = 8'd127;
      2: force u2.subframe_r = 8'd128;
      3: begin force u2.subframe_r = 8'd254; force u2.frame_r = 6'd63; end
      4: begin release u2.subframe_r; release u2.frame_r; end
      default: ;
    endcase
    case (fc3)
      1: force u3.subframe_r = 8'd127;
      2: force u3.subframe_r = 8'd128;
      3: begin force u3.subframe_r = 8'd254; force u3.frame_r = 6'd63; end
      4: begin release u3.subframe_r; release u3.frame_r; end
      default: ;
    endcase
    if (rc2 == 1) rst2 = 1'b1;
    else if (rc2 == 2) rst2 = 1'b0;
    if (rc3 == 1) rst3 = 1'b1;
    else if (rc3 == 2) rst3 = 1'b0;
  end

  initial begin
    for (int n = 0; n < 12000 && !(seq_m[0] >= 37 && seq_m[1] >= 37); n++) @(posedge clk);
    if (!(seq_m[0] >= 37 && seq_m[1] >= 37)) begin
      checks++;
      errors++;
      $display("FAIL timeout: rows completed %0d/%0d, required 37/37", seq_m[0], seq_m[1]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
